// File: rtl/seq_divider_if.sv
// Start/valid handshake bus for seq_divider: operands in, registered result and status out.
interface seq_divider_if #(
    parameter int nb = 4
);
    logic          start;
    logic [nb-1:0] dividend;
    logic [nb-1:0] divisor;
    logic [nb-1:0] quotient;
    logic [nb-1:0] remainder;
    logic          valid;
    logic          busy;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, valid, busy, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, valid, busy, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential signed divider: one non-restoring step per clock on operand magnitudes,
// then a remainder restore cycle and a sign-correction cycle before results are held.
module seq_divider #(
    parameter int nb = 4
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int cw = $clog2(nb + 1);

    typedef enum logic [2:0] {IDLE, ITER, FIX, SIGN, DONE} state_t;

    state_t               state, state_nx;
    logic [cw-1:0]        count;
    logic signed [nb+1:0] p;
    logic [nb-1:0]        a;
    logic [nb:0]          mag_dvs;
    logic                 sign_dvd, sign_dvs, ovf_cand;
    logic [nb-1:0]        quotient_q, remainder_q;
    logic                 valid_q, dz_q, ovf_q, busy_c;

    logic [nb-1:0]        dvd_abs;
    logic [nb:0]          dvs_sx, dvs_abs;
    logic signed [nb+1:0] d_ext, p_sh, p_step;
    logic [nb-1:0]        q_res, r_res, dvd_back;

    // Magnitudes fit unsigned: |-2^(nb-1)| needs nb bits for the dividend, nb+1 latched for the divisor.
    always_comb begin
        dvd_abs  = bus.dividend[nb-1] ? -bus.dividend : bus.dividend;
        dvs_sx   = {bus.divisor[nb-1], bus.divisor};
        dvs_abs  = dvs_sx[nb] ? -dvs_sx : dvs_sx;
        d_ext    = {1'b0, mag_dvs};
        p_sh     = {p[nb:0], a[nb-1]};
        p_step   = p[nb+1] ? p_sh + d_ext : p_sh - d_ext;
        q_res    = (sign_dvd ^ sign_dvs) ? -a : a;
        r_res    = sign_dvd ? -p[nb-1:0] : p[nb-1:0];
        dvd_back = sign_dvd ? -a : a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: default first, so no branch leaves state_nx unassigned and no latch is inferred.
        state_nx = state;
        if (bus.start) begin
            state_nx = (bus.divisor == '0) ? DONE : ITER;
        end else begin
            case (state)
                ITER:    if (count == cw'(1)) state_nx = FIX;
                FIX:     state_nx = SIGN;
                SIGN:    state_nx = DONE;
                IDLE,
                DONE:    state_nx = state;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_c = (state == ITER) || (state == FIX) || (state == SIGN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            count       <= '0;
            p           <= '0;
            a           <= '0;
            mag_dvs     <= '0;
            sign_dvd    <= 1'b0;
            sign_dvs    <= 1'b0;
            ovf_cand    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (bus.start) begin
            sign_dvd <= bus.dividend[nb-1];
            sign_dvs <= bus.divisor[nb-1];
            a        <= dvd_abs;
            mag_dvs  <= dvs_abs;
            ovf_cand <= (bus.dividend == {1'b1, {(nb-1){1'b0}}}) && (&bus.divisor);
            count    <= cw'(nb);
            p        <= '0;
            valid_q  <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                ITER: begin
                    p     <= p_step;
                    a     <= {a[nb-2:0], ~p_step[nb+1]};
                    count <= count - cw'(1);
                end
                FIX: if (p[nb+1]) p <= p + d_ext;
                SIGN: begin
                    quotient_q  <= q_res;
                    remainder_q <= r_res;
                    ovf_q       <= ovf_cand;
                    valid_q     <= 1'b1;
                end
                // Only the divide-by-zero path reaches DONE without a result written.
                DONE: if (!valid_q) begin
                    quotient_q  <= '1;
                    remainder_q <= dvd_back;
                    dz_q        <= 1'b1;
                    valid_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.valid       = valid_q;
    assign bus.busy        = busy_c;
    assign bus.div_by_zero = dz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: integer-arithmetic reference with a cycle-count
// timing model compared every cycle, plus directed literal cases and random traffic.
module tb_seq_divider;
    localparam int nb = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    seq_divider_if #(.nb(nb)) bus ();
    seq_divider #(.nb(nb)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [nb-1:0] ref_q(input logic [nb-1:0] x, input logic [nb-1:0] y);
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        if (sy == 0) return '1;
        return nb'(sx / sy);
    endfunction

    function automatic logic [nb-1:0] ref_r(input logic [nb-1:0] x, input logic [nb-1:0] y);
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        if (sy == 0) return x;
        return nb'(sx % sy);
    endfunction

    function automatic logic ref_ovf(input logic [nb-1:0] x, input logic [nb-1:0] y);
        int sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return (sx == -(2 ** (nb - 1))) && (sy == -1);
    endfunction

    // Model: results computed at the start edge, released after a fixed number of edges.
    logic          m_active, m_valid, m_busy, m_dz, m_ovf;
    logic [nb-1:0] m_q, m_r, p_q, p_r;
    logic          p_dz, p_ovf;
    int            m_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_k <= 0;
            m_valid <= 1'b0; m_busy <= 1'b0; m_dz <= 1'b0; m_ovf <= 1'b0;
            m_q <= '0; m_r <= '0;
            p_q <= '0; p_r <= '0; p_dz <= 1'b0; p_ovf <= 1'b0;
        end else if (bus.start) begin
            m_active <= 1'b1;
            m_k      <= 0;
            p_q      <= ref_q(bus.dividend, bus.divisor);
            p_r      <= ref_r(bus.dividend, bus.divisor);
            p_dz     <= (bus.divisor == '0);
            p_ovf    <= ref_ovf(bus.dividend, bus.divisor);
            m_busy   <= (bus.divisor != '0);
            m_valid  <= 1'b0;
            m_dz     <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (m_active && m_k < 1000) begin
            m_k    <= m_k + 1;
            m_busy <= !p_dz && (m_k + 1 <= nb + 1);
            if (m_k + 1 == (p_dz ? 1 : nb + 2)) begin
                m_q     <= p_q;
                m_r     <= p_r;
                m_dz    <= p_dz;
                m_ovf   <= p_ovf;
                m_valid <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if ({bus.valid, bus.busy, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder} !==
            {m_valid, m_busy, m_dz, m_ovf, m_q, m_r}) begin
            miscompares++;
            $display("FAIL cycle t=%0t: dut v=%b b=%b dz=%b ov=%b q=%b r=%b, expected v=%b b=%b dz=%b ov=%b q=%b r=%b",
                     $time, bus.valid, bus.busy, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder,
                     m_valid, m_busy, m_dz, m_ovf, m_q, m_r);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic op(input logic [nb-1:0] x, input logic [nb-1:0] y, input int hold);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = x;
        bus.divisor  = y;
        repeat (hold) @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = nb'($urandom);
        bus.divisor  = nb'($urandom);
    endtask

    // Waits from the negedge after the last start edge; latency counts edges until valid shows.
    task automatic expect_done(input string name, input int lat, input logic [nb-1:0] q,
                               input logic [nb-1:0] r, input logic dz, input logic ovf);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                n = i;
                break;
            end
        end
        check({name, " latency"}, n, lat);
        check({name, " quotient"}, bus.quotient, q);
        check({name, " remainder"}, bus.remainder, r);
        check({name, " div_by_zero"}, bus.div_by_zero, dz);
        check({name, " overflow"}, bus.overflow, ovf);
        check({name, " busy"}, bus.busy, 1'b0);
    endtask

    logic [nb-1:0] rx, ry;

    initial begin
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        check("reset valid", bus.valid, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset quotient", bus.quotient, '0);
        check("reset remainder", bus.remainder, '0);
        check("reset flags", {bus.div_by_zero, bus.overflow}, 2'b00);
        rst_n = 1'b1;

        op(4'b0111, 4'b0010, 1); expect_done("7/2", 6, 4'b0011, 4'b0001, 1'b0, 1'b0);
        op(4'b1001, 4'b0010, 1); expect_done("-7/2", 6, 4'b1101, 4'b1111, 1'b0, 1'b0);
        op(4'b0111, 4'b1110, 1); expect_done("7/-2", 6, 4'b1101, 4'b0001, 1'b0, 1'b0);
        op(4'b1001, 4'b1110, 1); expect_done("-7/-2", 6, 4'b0011, 4'b1111, 1'b0, 1'b0);
        op(4'b1000, 4'b1111, 1); expect_done("-8/-1", 6, 4'b1000, 4'b0000, 1'b0, 1'b1);
        op(4'b1000, 4'b0001, 1); expect_done("-8/1", 6, 4'b1000, 4'b0000, 1'b0, 1'b0);
        op(4'b0000, 4'b0101, 1); expect_done("0/5", 6, 4'b0000, 4'b0000, 1'b0, 1'b0);
        op(4'b0101, 4'b0000, 1); expect_done("5/0", 1, 4'b1111, 4'b0101, 1'b1, 1'b0);
        op(4'b0110, 4'b0011, 1); expect_done("6/3", 6, 4'b0010, 4'b0000, 1'b0, 1'b0);

        // Restart two edges into 7/2 with 6/4; only the second result may appear.
        op(4'b0111, 4'b0010, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 4'b0110; bus.divisor = 4'b0100;
        @(negedge clk);
        bus.start = 1'b0;
        expect_done("restart 6/4", 6, 4'b0001, 4'b0010, 1'b0, 1'b0);

        // Async reset while iterating, asserted between edges.
        op(4'b0111, 4'b0010, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset busy", bus.busy, 1'b0);
        check("mid reset valid", bus.valid, 1'b0);
        check("mid reset quotient", bus.quotient, '0);
        check("mid reset remainder", bus.remainder, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle after reset valid", bus.valid, 1'b0);
        end

        op(4'b0111, 4'b0010, 3); expect_done("held start 7/2", 6, 4'b0011, 4'b0001, 1'b0, 1'b0);

        // Random traffic, including restarts before completion; the per-cycle compare checks it.
        for (int n = 0; n < 300; n++) begin
            rx = nb'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? '0 : nb'($urandom);
            op(rx, ry, int'($urandom_range(1, 2)));
            repeat ($urandom_range(0, nb + 4)) @(negedge clk);
        end
        repeat (nb + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
